// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle rasterizer.
// Coordinate and edge-result types, FSM state enum and small
// min/max helpers used for the bounding-box computation.
package tri_pkg;

  localparam int unsigned CW   = 11;
  localparam int unsigned CNTW = 2 * CW;
  // Edge result width: two (CW+1)-bit signed differences multiplied.
  localparam int unsigned EW   = 2 * (CW + 1);

  typedef logic [CW-1:0]        coord_t;
  typedef logic signed [EW-1:0] edge_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_edge_fn.sv
// Combinational edge function e(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
// Differences are CW+1 bits signed; the result is 2*(CW+1) bits signed,
// wide enough that neither products nor their difference can overflow.
module tri_edge_fn
  import tri_pkg::*;
(
  input  logic [CW-1:0]        i_ax,
  input  logic [CW-1:0]        i_ay,
  input  logic [CW-1:0]        i_bx,
  input  logic [CW-1:0]        i_by,
  input  logic [CW-1:0]        i_px,
  input  logic [CW-1:0]        i_py,
  output logic signed [EW-1:0] o_e
);

  logic signed [CW:0]   w_dxb;
  logic signed [CW:0]   w_dyp;
  logic signed [CW:0]   w_dyb;
  logic signed [CW:0]   w_dxp;
  logic signed [EW-1:0] w_p0;
  logic signed [EW-1:0] w_p1;

  assign w_dxb = $signed({1'b0, i_bx}) - $signed({1'b0, i_ax});
  assign w_dyp = $signed({1'b0, i_py}) - $signed({1'b0, i_ay});
  assign w_dyb = $signed({1'b0, i_by}) - $signed({1'b0, i_ay});
  assign w_dxp = $signed({1'b0, i_px}) - $signed({1'b0, i_ax});

  assign w_p0 = $signed({{(CW+1){w_dxb[CW]}}, w_dxb}) * $signed({{(CW+1){w_dyp[CW]}}, w_dyp});
  assign w_p1 = $signed({{(CW+1){w_dyb[CW]}}, w_dyb}) * $signed({{(CW+1){w_dxp[CW]}}, w_dxp});
  assign o_e  = w_p0 - w_p1;

endmodule

// File: rtl/tri_raster_scan.sv
// Sequential triangle rasterizer: accepts three vertices, walks the
// bounding box row-major one candidate per cycle, and streams covered
// pixels over valid/ready. Pixels on an edge count as covered.
// Optional macro TRI_RASTER_BOTH_WINDING_EN: also accept pixels whose
// three edge values are all >= 0, so either winding rasterizes.
module tri_raster_scan #(
  parameter int unsigned CW   = 11,
  parameter int unsigned CNTW = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   x1,
  input  logic [CW-1:0]   y1,
  input  logic [CW-1:0]   x2,
  input  logic [CW-1:0]   y2,
  input  logic [CW-1:0]   x3,
  input  logic [CW-1:0]   y3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_x,
  output logic [CW-1:0]   out_y,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] pix_count
);

  import tri_pkg::*;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  logic [CW-1:0] r_xmin, r_xmax, r_ymax;
  logic [CW-1:0] r_px, r_py;
  logic [CW-1:0] r_out_x, r_out_y;
  logic          r_out_valid;
  logic [CNTW-1:0] r_pix_count;

  logic signed [EW-1:0] w_e12, w_e23, w_e31;
  logic w_cov;
  logic w_stall;
  logic w_last;
  logic w_accept;

  tri_edge_fn u_edge12 (
    .i_ax (r_x1), .i_ay (r_y1),
    .i_bx (r_x2), .i_by (r_y2),
    .i_px (r_px), .i_py (r_py),
    .o_e  (w_e12)
  );

  tri_edge_fn u_edge23 (
    .i_ax (r_x2), .i_ay (r_y2),
    .i_bx (r_x3), .i_by (r_y3),
    .i_px (r_px), .i_py (r_py),
    .o_e  (w_e23)
  );

  tri_edge_fn u_edge31 (
    .i_ax (r_x3), .i_ay (r_y3),
    .i_bx (r_x1), .i_by (r_y1),
    .i_px (r_px), .i_py (r_py),
    .o_e  (w_e31)
  );

  // Coverage decision for the current scan pointer.
  always_comb begin
    w_cov = (w_e12 <= 0) && (w_e23 <= 0) && (w_e31 <= 0);
`ifdef TRI_RASTER_BOTH_WINDING_EN
    if ((w_e12 >= 0) && (w_e23 >= 0) && (w_e31 >= 0)) begin
      w_cov = 1'b1;
    end
`endif
  end

  assign w_stall  = r_out_valid && !out_ready;
  assign w_last   = (r_px == r_xmax) && (r_py == r_ymax);
  assign w_accept = in_valid && (r_state == ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!w_stall && w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_out_valid || out_ready) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Vertex/bbox latch, scan pointer, output pixel register and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x1        <= '0;
      r_y1        <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
      r_x3        <= '0;
      r_y3        <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_valid <= 1'b0;
      r_pix_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x1        <= x1;
            r_y1        <= y1;
            r_x2        <= x2;
            r_y2        <= y2;
            r_x3        <= x3;
            r_y3        <= y3;
            r_xmin      <= min3(x1, x2, x3);
            r_xmax      <= max3(x1, x2, x3);
            r_ymax      <= max3(y1, y2, y3);
            r_px        <= min3(x1, x2, x3);
            r_py        <= min3(y1, y2, y3);
            r_pix_count <= '0;
          end
        end
        ST_SCAN: begin
          if (!w_stall) begin
            if (w_cov) begin
              r_out_x     <= r_px;
              r_out_y     <= r_py;
              r_out_valid <= 1'b1;
              r_pix_count <= r_pix_count + CNTW'(1);
            end else begin
              r_out_valid <= 1'b0;
            end
            // Pointer parks on (xmax,ymax) after the last candidate.
            if (!w_last) begin
              if (r_px == r_xmax) begin
                r_px <= r_xmin;
                r_py <= r_py + CW'(1);
              end else begin
                r_px <= r_px + CW'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign pix_count = r_pix_count;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Scoreboard bench for tri_raster_scan: stimulus pushes expected pixels
// and per-triangle counts; a monitor on the falling edge pops and compares.
module tb_tri_raster_scan;

  localparam int unsigned CW   = 11;
  localparam int unsigned CNTW = 22;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   x1, y1, x2, y2, x3, y3;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_x, out_y;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] pix_count;

  int n_vec = 0;
  int n_err = 0;
  int n_stall_chk = 0;

  logic [2*CW-1:0] exp_pix_q[$];
  int              exp_cnt_q[$];

  always #5 clk = ~clk;

  tri_raster_scan #(.CW(CW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .x3        (x3),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected pixels of a right triangle with legs of length n at (ox,oy):
  // covered set is x+y <= n (relative), emitted row-major.
  task automatic push_corner(input int ox, input int oy, input int n);
    for (int y = 0; y <= n; y++) begin
      for (int x = 0; x <= n - y; x++) begin
        exp_pix_q.push_back({CW'(ox + x), CW'(oy + y)});
      end
    end
  endtask

  // Monitor: pops expected pixels on handshakes, checks held data while
  // stalled, and checks counts and drain completion on each done pulse.
  logic          p_stall = 1'b0;
  logic [CW-1:0] p_x = '0;
  logic [CW-1:0] p_y = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_stall) begin
        chk("stall_hold", longint'({out_valid, out_x, out_y}), longint'({1'b1, p_x, p_y}));
        n_stall_chk++;
      end
      if (out_valid && out_ready) begin
        if (exp_pix_q.size() == 0) begin
          chk("pixel_unexpected", longint'({out_x, out_y}), -1);
        end else begin
          chk("pixel_xy", longint'({out_x, out_y}), longint'(exp_pix_q.pop_front()));
        end
      end
      if (done) begin
        chk("done_busy", longint'(busy), 1);
        chk("done_queue_empty", exp_pix_q.size(), 0);
        if (exp_cnt_q.size() == 0) begin
          chk("done_unexpected", exp_cnt_q.size(), 1);
        end else begin
          chk("pix_count_done", longint'(pix_count), exp_cnt_q.pop_front());
        end
      end
    end
    p_stall = rst_n && out_valid && !out_ready;
    p_x     = out_x;
    p_y     = out_y;
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_in_ready", longint'(in_ready), 1);
    x1 = CW'(ax); y1 = CW'(ay);
    x2 = CW'(bx); y2 = CW'(by);
    x3 = CW'(cx); y3 = CW'(cy);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 500) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      t++;
    end
    chk("done_seen", longint'(seen), 1);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("busy_after_done", longint'(busy), 0);
    chk("in_ready_after_done", longint'(in_ready), 1);
    chk("pix_count_hold", longint'(pix_count), exp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    int stall_base;
    int rev_cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_xy", longint'({out_x, out_y}), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_pix_count", longint'(pix_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic triangle: 15 pixels.
    push_corner(0, 0, 4);
    exp_cnt_q.push_back(15);
    send(0, 0, 0, 4, 4, 0);
    chk("busy_after_accept", longint'(busy), 1);
    wait_done(15);

    // Reverse winding.
`ifdef TRI_RASTER_BOTH_WINDING_EN
    push_corner(0, 0, 4);
    rev_cnt = 15;
`else
    rev_cnt = 0;
`endif
    exp_cnt_q.push_back(rev_cnt);
    send(0, 0, 4, 0, 0, 4);
    wait_done(rev_cnt);

    // Single-point bbox.
    exp_pix_q.push_back({CW'(5), CW'(5)});
    exp_cnt_q.push_back(1);
    send(5, 5, 5, 5, 5, 5);
    wait_done(1);

    // Back-pressure: hold out_ready low for 10 cycles after first out_valid.
    push_corner(0, 0, 4);
    exp_cnt_q.push_back(15);
    send(0, 0, 0, 4, 4, 0);
    out_ready = 1'b0;
    stall_base = n_stall_chk;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_first_valid", longint'(out_valid), 1);
    chk("stall_first_xy", longint'({out_x, out_y}), 0);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("stall_cycles_seen", longint'(n_stall_chk - stall_base >= 9), 1);
    wait_done(15);

    // Reset during scan, then a fresh triangle.
    push_corner(0, 0, 4);
    exp_cnt_q.push_back(15);
    send(0, 0, 0, 4, 4, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_pix_q.delete();
    exp_cnt_q.delete();
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_pix_count", longint'(pix_count), 0);
    push_corner(10, 10, 2);
    exp_cnt_q.push_back(6);
    send(10, 10, 10, 12, 12, 10);
    wait_done(6);

    // in_valid while busy must be ignored.
    push_corner(0, 0, 4);
    exp_cnt_q.push_back(15);
    send(0, 0, 0, 4, 4, 0);
    x1 = CW'(5); y1 = CW'(5); x2 = CW'(5); y2 = CW'(5); x3 = CW'(5); y3 = CW'(5);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("in_ready_while_busy", longint'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(15);
    chk("final_queue_empty", exp_pix_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tri_raster_scan.md
Name: tri_raster_scan

Overview:
- Sequential triangle rasterizer; accepts three vertices over a valid/ready handshake.
- Walks the triangle's bounding box in row-major order and runs the three-edge cross-product inside test on each candidate pixel.
- Streams covered pixel coordinates downstream over valid/ready.
- Produces the (cx, cy) candidates and consumes the coverage decision, so it is the driver end of the point-in-triangle test used elsewhere in the graphics path.

Parameters:
- CW, 11, coordinate width (unsigned screen coordinates).
- CNTW, 22, width of covered-pixel counter (2*CW).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  triangle descriptor valid
- in_ready  out  1  block can accept a triangle (high only in IDLE)
- x1,y1,x2,y2,x3,y3  in  CW each  vertex coordinates, unsigned
- out_valid  out  1  covered pixel available
- out_ready  in  1  downstream accepts pixel
- out_x,out_y  out  CW  covered pixel coordinate
- busy  out  1  high from descriptor accept until done pulse inclusive
- done  out  1  one-cycle pulse: triangle fully rasterized and all pixels delivered
- pix_count  out  CNTW  covered pixels emitted for current/last triangle

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - in_ready=1; out_valid=0, out_x=0, out_y=0, busy=0, done=0, pix_count=0.
  - Reset mid-scan abandons the triangle; a held output pixel is dropped.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: latch vertices, compute bbox xmin/xmax/ymin/ymax = min/max of the vertex coordinates, set scan pointer to (xmin,ymin), clear pix_count, go to SCAN.
- SCAN: one candidate per cycle when not stalled.
  - Edge function e(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
    - Differences are 12-bit signed; products and result are 24-bit signed, with no overflow possible.
  - Edges evaluated: e(v1,v2,p), e(v2,v3,p), e(v3,v1,p).
  - Covered iff all three <= 0. Pixels exactly on an edge are covered.
  - Stall condition: out_valid=1 and out_ready=0. While stalled the pointer holds, and out_x/out_y/out_valid stay stable.
  - When not stalled:
    - Current candidate covered: load out_x/out_y, set out_valid, increment pix_count.
    - Otherwise: clear out_valid if it was just accepted.
  - Pointer advance: x++; when x==xmax, x=xmin and y++.
  - After evaluating (xmax,ymax), go to DRAIN.
- DRAIN:
  - Wait until out_valid=0, or out_valid&out_ready handshake completes.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops with the IDLE transition.
- Latency:
  - First candidate is evaluated in cycle T+1.
  - Earliest out_valid is at T+2.
  - Throughput is 1 candidate/cycle with out_ready held high.
- Boundary conditions:
  - Degenerate triangles (collinear or coincident vertices) are rasterized normally. Points on the line are covered; a single-point bbox gives exactly one candidate.
  - Coordinates up to 2047 wrap-free; the pointer never exceeds xmax/ymax.
  - in_valid outside IDLE is ignored (in_ready=0).
  - pix_count holds its value after DONE until the next accept.

Optional Feature:
- Macro: TRI_RASTER_BOTH_WINDING_EN.
- Defined: a pixel is covered if all three edges <= 0 OR all three >= 0, so both vertex orderings rasterize identically.
- Undefined: only the all <= 0 rule applies; reverse-wound triangles produce zero pixels but still pulse done.

Decomposition:
- Shared package tri_pkg:
  - Coordinate type (CW-bit unsigned).
  - Edge result type (24-bit signed).
  - FSM state enum.
  - Constant CW=11.
- Sub-module tri_edge_fn: combinational e(a,b,p). Instantiated three times.

Test Plan:
- Triangle (0,0),(0,4),(4,0), out_ready=1 -> 15 pixels, first (0,0), last (0,4), row y=0 gives x=0..4; pix_count=15; one done pulse.
- Same vertices reversed (0,0),(4,0),(0,4) -> 0 pixels and done pulse without macro; 15 identical pixels with TRI_RASTER_BOTH_WINDING_EN.
- All vertices (5,5) -> exactly one pixel (5,5); pix_count=1.
- Triangle (0,0),(0,4),(4,0) with out_ready low for 10 cycles after first out_valid -> out_x/out_y=(0,0) stable throughout; no pixel lost or duplicated; total still 15.
- rst_n low for one cycle during SCAN of the first triangle, then triangle (10,10),(10,12),(12,10) -> out_valid=0 immediately after reset; second triangle yields 6 pixels; pix_count=6.
- in_valid asserted during busy with a different triangle -> ignored; in_ready=0; only the first triangle's pixels appear.
